mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL have one clock `clk` and one reset `reset`; reset SHALL be asynchronous and active-high.
REQ-002 Port list (name, direction, width, meaning):
- `clk`  in  1  rising-edge clock
- `reset`  in  1  async active-high reset
- `RegWrite`  in  1  writeback enable from EX/MEM
- `MemtoReg`  in  1  writeback source select from EX/MEM
- `MemWrite`  in  1  store request
- `MemRead`  in  1  load request
- `AluResult`  in  64  address for load/store, or ALU value for writeback
- `Datain`  in  64  store data
- `Rd_in`  in  5  destination register
- `RegWrite_Out`  out  1  registered writeback enable
- `MemtoReg_Out`  out  1  registered source select
- `ReadData`  out  64  registered load data
- `AluOut`  out  64  registered ALU value
- `Rd_out`  out  5  registered destination
- `Stall`  out  1  combinational; upstream must hold EX/MEM stable
- `Misalign`  out  1  registered one-cycle fault pulse

Function
REQ-003 The block SHALL contain a data memory of 32 x 64-bit words, indexed by AluResult[7:3]; bits [63:8] SHALL be ignored, so addresses wrap modulo 256.
REQ-004 An access SHALL be misaligned when AluResult[2:0] != 0 and (MemRead or MemWrite) is 1.
REQ-005 The FSM SHALL have two states: IDLE and LOAD.
REQ-006 In IDLE with an aligned load and MemWrite=0:
- Stall=1 combinationally that cycle.
- The FSM moves to LOAD.
- The output register captures a bubble: RegWrite_Out=0, MemtoReg_Out=0, Rd_out=0; AluOut and ReadData hold.
REQ-007 In LOAD:
- Stall=0.
- ReadData captures mem[AluResult[7:3]] at the next edge.
- RegWrite_Out, MemtoReg_Out, AluOut and Rd_out capture the inputs.
- The FSM returns to IDLE.
- Load latency is 2 edges from input presentation to valid output.
REQ-008 In IDLE with an aligned store (MemWrite=1):
- mem[AluResult[7:3]] is written with Datain at the edge.
- There is no stall.
- The control/ALU fields pass through to the outputs one cycle later.
REQ-009 MemWrite=1 with MemRead=1 SHALL be treated as a store; the read is ignored and there is no stall.
REQ-010 A misaligned access SHALL:
- suppress the memory read or write;
- not stall;
- register Misalign=1 for exactly one cycle;
- force RegWrite_Out=0 for that op.
REQ-011 For a non-memory op (MemRead=0, MemWrite=0), all input fields SHALL be registered to the outputs with 1-cycle latency, ReadData holding its value and Misalign=0.
REQ-012 In LOAD, MemWrite and a misalignment check SHALL NOT be re-evaluated, because the inputs are guaranteed held from IDLE.
REQ-013 Stall SHALL depend only on the FSM state, MemRead, MemWrite and AluResult[2:0], and SHALL have no path from the memory array.
REQ-014 Back-to-back loads SHALL each take 2 cycles, giving a Stall pattern of 1,0,1,0.

Reset
REQ-015 While reset=1:
- The FSM SHALL be IDLE.
- RegWrite_Out, MemtoReg_Out, Misalign SHALL be 0.
- ReadData, AluOut SHALL be 64'h0.
- Rd_out SHALL be 5'h0.
- Stall SHALL follow REQ-006 from IDLE.
REQ-016 Memory contents SHALL NOT be affected by reset.
REQ-017 Reset asserted while in LOAD SHALL abort the load: no output update, and the FSM is in IDLE at deassertion.
REQ-018 Reset asserted during a store edge SHALL NOT be required to block the write; the bench SHALL NOT rely on either outcome.

Verification
REQ-019 Apply reset for 10 ns, then release: all outputs read 0, Stall=0 with idle inputs.
REQ-020 Store then load:
- Store AluResult=64'h10, Datain=64'hDEADBEEFCAFEF00D, then load AluResult=64'h10, Rd_in=5'd7, RegWrite=1, MemtoReg=1.
- Response: Stall=1 for one cycle, then ReadData=64'hDEADBEEFCAFEF00D, Rd_out=7, RegWrite_Out=1.
REQ-021 Pass-through: RegWrite=1, AluResult=64'h1234, Rd_in=5'd3, no memory op -> next cycle AluOut=64'h1234, Rd_out=3, RegWrite_Out=1, Stall never 1.
REQ-022 Misaligned store:
- Store to AluResult=64'h13, then aligned load from 64'h10.
- Response: Misalign=1 for one cycle, and the load returns the prior contents of word 2 unchanged.
REQ-023 Wrap-around: store 64'hA5 at AluResult=64'h100, then load from 64'h0 -> ReadData=64'hA5.
REQ-024 Reset mid-load: assert reset during the LOAD cycle -> outputs stay 0 and there is no Rd_out update; a subsequent load completes normally in 2 cycles.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage with a small local data memory.
// Loads take two cycles: the first cycle stalls upstream and emits a bubble,
// the second cycle reads the array and registers the result. Stores and
// non-memory ops pass straight through with one cycle of latency.
// Misaligned accesses are dropped, flagged with a one-cycle pulse and never
// allowed to write back.

module mem_wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [63:0] AluResult,
    input  logic [63:0] Datain,
    input  logic [4:0]  Rd_in,
    output logic        RegWrite_Out,
    output logic        MemtoReg_Out,
    output logic [63:0] ReadData,
    output logic [63:0] AluOut,
    output logic [4:0]  Rd_out,
    output logic        Stall,
    output logic        Misalign
);

    typedef enum logic [0:0] {
        StIdle,
        StLoad
    } state_t;

    state_t state;

    // 32 x 64-bit data memory; deliberately not reset
    logic [63:0] mem [0:31];

    logic [4:0] word_idx;
    logic       mem_access;
    logic       misaligned;
    logic       is_store;
    logic       is_load;
    logic       do_write;

    // Address bits above the array are ignored, so addresses wrap modulo 256
    logic       unused_addr_hi;

    assign word_idx       = AluResult[7:3];
    assign unused_addr_hi = ^AluResult[63:8];

    // Access decode; Stall is driven only by state, request bits and AluResult[2:0]
    always_comb begin
        mem_access = MemRead | MemWrite;
        misaligned = mem_access && (AluResult[2:0] != 3'b000);
        // A combined read+write request is a store
        is_store   = MemWrite && !misaligned;
        is_load    = MemRead && !MemWrite && !misaligned;
        Stall      = (state == StIdle) && is_load;
        do_write   = (state == StIdle) && is_store;
    end

    // Stage FSM and registered pipeline outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= StIdle;
            RegWrite_Out <= 1'b0;
            MemtoReg_Out <= 1'b0;
            ReadData     <= 64'h0;
            AluOut       <= 64'h0;
            Rd_out       <= 5'h0;
            Misalign     <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    Misalign <= misaligned;
                    if (is_load) begin
                        // First load cycle: insert a bubble, hold data fields
                        state        <= StLoad;
                        RegWrite_Out <= 1'b0;
                        MemtoReg_Out <= 1'b0;
                        Rd_out       <= 5'h0;
                    end else begin
                        // Store, non-memory op or dropped misaligned access
                        RegWrite_Out <= RegWrite && !misaligned;
                        MemtoReg_Out <= MemtoReg;
                        AluOut       <= AluResult;
                        Rd_out       <= Rd_in;
                    end
                end
                StLoad: begin
                    // Inputs are held from the stalled cycle, so no re-decode here
                    state        <= StIdle;
                    Misalign     <= 1'b0;
                    ReadData     <= mem[word_idx];
                    RegWrite_Out <= RegWrite;
                    MemtoReg_Out <= MemtoReg;
                    AluOut       <= AluResult;
                    Rd_out       <= Rd_in;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    // Memory write port; only aligned stores issued from idle
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[word_idx] <= Datain;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage.

module tb_mem_wb_stage;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic        MemtoReg;
    logic        MemWrite;
    logic        MemRead;
    logic [63:0] AluResult;
    logic [63:0] Datain;
    logic [4:0]  Rd_in;
    logic        RegWrite_Out;
    logic        MemtoReg_Out;
    logic [63:0] ReadData;
    logic [63:0] AluOut;
    logic [4:0]  Rd_out;
    logic        Stall;
    logic        Misalign;

    int tests;
    int fails;

    mem_wb_stage dut (
        .clk          (clk),
        .reset        (reset),
        .RegWrite     (RegWrite),
        .MemtoReg     (MemtoReg),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .AluResult    (AluResult),
        .Datain       (Datain),
        .Rd_in        (Rd_in),
        .RegWrite_Out (RegWrite_Out),
        .MemtoReg_Out (MemtoReg_Out),
        .ReadData     (ReadData),
        .AluOut       (AluOut),
        .Rd_out       (Rd_out),
        .Stall        (Stall),
        .Misalign     (Misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        RegWrite  = 1'b0;
        MemtoReg  = 1'b0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        AluResult = 64'h0;
        Datain    = 64'h0;
        Rd_in     = 5'h0;
    endtask

    task automatic set_op(input logic rw, input logic mtr, input logic mw, input logic mr,
                          input logic [63:0] alu, input logic [63:0] din, input logic [4:0] rd);
        RegWrite  = rw;
        MemtoReg  = mtr;
        MemWrite  = mw;
        MemRead   = mr;
        AluResult = alu;
        Datain    = din;
        Rd_in     = rd;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_regwrite"}, {63'h0, RegWrite_Out}, 64'h0);
        check({tag, "_memtoreg"}, {63'h0, MemtoReg_Out}, 64'h0);
        check({tag, "_readdata"}, ReadData, 64'h0);
        check({tag, "_aluout"}, AluOut, 64'h0);
        check({tag, "_rd"}, {59'h0, Rd_out}, 64'h0);
        check({tag, "_misalign"}, {63'h0, Misalign}, 64'h0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        idle_inputs();

        // Reset behaviour
        #2;
        check_zero_outputs("rst");
        set_op(1'b0, 1'b0, 1'b0, 1'b1, 64'h10, 64'h0, 5'd0);
        #1;
        check("rst_stall_load", {63'h0, Stall}, 64'h1);
        idle_inputs();
        #1;
        check("rst_stall_idle", {63'h0, Stall}, 64'h0);
        #6;
        reset = 1'b0;
        tick();
        check_zero_outputs("post_rst");
        check("post_rst_stall", {63'h0, Stall}, 64'h0);

        // Store DEADBEEFCAFEF00D to word 2
        set_op(1'b0, 1'b0, 1'b1, 1'b0, 64'h10, 64'hDEADBEEFCAFEF00D, 5'd0);
        #1;
        check("st_stall", {63'h0, Stall}, 64'h0);
        tick();
        check("st_aluout", AluOut, 64'h10);
        check("st_misalign", {63'h0, Misalign}, 64'h0);

        // Load it back
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 64'h10, 64'h0, 5'd7);
        #1;
        check("ld_stall1", {63'h0, Stall}, 64'h1);
        tick();
        check("ld_stall2", {63'h0, Stall}, 64'h0);
        check("ld_bubble_rw", {63'h0, RegWrite_Out}, 64'h0);
        check("ld_bubble_rd", {59'h0, Rd_out}, 64'h0);
        check("ld_bubble_rdata", ReadData, 64'h0);
        tick();
        check("ld_rdata", ReadData, 64'hDEADBEEFCAFEF00D);
        check("ld_rd", {59'h0, Rd_out}, 64'd7);
        check("ld_rw", {63'h0, RegWrite_Out}, 64'h1);
        check("ld_mtr", {63'h0, MemtoReg_Out}, 64'h1);
        idle_inputs();

        // Pass-through
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 64'h1234, 64'h0, 5'd3);
        #1;
        check("pt_stall", {63'h0, Stall}, 64'h0);
        tick();
        check("pt_aluout", AluOut, 64'h1234);
        check("pt_rd", {59'h0, Rd_out}, 64'd3);
        check("pt_rw", {63'h0, RegWrite_Out}, 64'h1);
        check("pt_rdata_hold", ReadData, 64'hDEADBEEFCAFEF00D);

        // Misaligned store must not touch word 2
        set_op(1'b1, 1'b0, 1'b1, 1'b0, 64'h13, 64'h1111, 5'd5);
        #1;
        check("mst_stall", {63'h0, Stall}, 64'h0);
        tick();
        check("mst_misalign", {63'h0, Misalign}, 64'h1);
        check("mst_rw", {63'h0, RegWrite_Out}, 64'h0);
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 64'h10, 64'h0, 5'd9);
        #1;
        check("mst_ld_stall", {63'h0, Stall}, 64'h1);
        tick();
        check("mst_misalign_pulse", {63'h0, Misalign}, 64'h0);
        tick();
        check("mst_ld_rdata", ReadData, 64'hDEADBEEFCAFEF00D);
        check("mst_ld_rd", {59'h0, Rd_out}, 64'd9);
        idle_inputs();

        // Misaligned load: no stall, flagged, no writeback
        set_op(1'b1, 1'b0, 1'b0, 1'b1, 64'h11, 64'h0, 5'd4);
        #1;
        check("mld_stall", {63'h0, Stall}, 64'h0);
        tick();
        check("mld_misalign", {63'h0, Misalign}, 64'h1);
        check("mld_rw", {63'h0, RegWrite_Out}, 64'h0);
        check("mld_rdata_hold", ReadData, 64'hDEADBEEFCAFEF00D);
        idle_inputs();
        tick();
        check("mld_misalign_clr", {63'h0, Misalign}, 64'h0);

        // Read+write together acts as a store to word 3
        set_op(1'b1, 1'b0, 1'b1, 1'b1, 64'h18, 64'h55AA55AA12345678, 5'd6);
        #1;
        check("rw_stall", {63'h0, Stall}, 64'h0);
        tick();
        check("rw_rw", {63'h0, RegWrite_Out}, 64'h1);
        check("rw_rd", {59'h0, Rd_out}, 64'd6);

        // Back-to-back loads: Stall 1,0,1,0
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 64'h10, 64'h0, 5'd10);
        #1;
        check("b2b_stall_a1", {63'h0, Stall}, 64'h1);
        tick();
        check("b2b_stall_a0", {63'h0, Stall}, 64'h0);
        tick();
        check("b2b_rdata_a", ReadData, 64'hDEADBEEFCAFEF00D);
        check("b2b_rd_a", {59'h0, Rd_out}, 64'd10);
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 64'h18, 64'h0, 5'd11);
        #1;
        check("b2b_stall_b1", {63'h0, Stall}, 64'h1);
        tick();
        check("b2b_stall_b0", {63'h0, Stall}, 64'h0);
        tick();
        check("b2b_rdata_b", ReadData, 64'h55AA55AA12345678);
        check("b2b_rd_b", {59'h0, Rd_out}, 64'd11);
        idle_inputs();

        // Wrap-around: 0x100 aliases word 0
        set_op(1'b0, 1'b0, 1'b1, 1'b0, 64'h100, 64'hA5, 5'd0);
        tick();
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 64'h0, 64'h0, 5'd2);
        tick();
        tick();
        check("wrap_rdata", ReadData, 64'hA5);
        check("wrap_rd", {59'h0, Rd_out}, 64'd2);
        idle_inputs();

        // Reset during the LOAD cycle aborts the load
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 64'h10, 64'h0, 5'd12);
        tick();
        reset = 1'b1;
        #1;
        check_zero_outputs("rml_async");
        tick();
        reset = 1'b0;
        #1;
        check_zero_outputs("rml_after");
        check("rml_stall1", {63'h0, Stall}, 64'h1);
        tick();
        check("rml_stall0", {63'h0, Stall}, 64'h0);
        check("rml_bubble_rd", {59'h0, Rd_out}, 64'h0);
        tick();
        check("rml_rdata", ReadData, 64'hDEADBEEFCAFEF00D);
        check("rml_rd", {59'h0, Rd_out}, 64'd12);
        check("rml_rw", {63'h0, RegWrite_Out}, 64'h1);
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
